get_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one IPPro core between NUM_CH input FIFOs. It extends the single-FIFO GET sequencing to several requesters. Each cycle it grants at most one non-empty FIFO, pulses its read enable, enables the core one cycle later with a channel tag, and tracks the tag through the core pipeline to an output write strobe. Output backpressure uses credits, so the core pipeline never needs to stall.

---
 rtl/get_rr_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_get_rr_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/get_rr_scheduler.sv
// ---------------------------------------------------------------------------
// get_rr_scheduler
//
// Shares one IPPro core between NUM_CH input FIFOs in round-robin order.
// Each cycle at most one non-empty FIFO is granted and popped. The popped
// word reaches the core one cycle later, flagged by ENABLE_CORE and tagged
// with CH_SEL. The tag then rides a CORE_LATENCY-deep valid/tag shift
// register alongside the core, so the result leaves as OUT_WRITE_EN/OUT_CH.
// The output FIFO is guarded by a credit counter, so an item is only issued
// when a slot is already reserved for its result. The core pipeline
// therefore never has to stall.
//
// Ports:
//   CLK           in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   ENABLE        in   run request; deassert = drain in-flight items and stop
//   EMPTY         in   per-input-FIFO empty flags [NUM_CH]
//   OUT_READ      in   downstream pop of the output FIFO; returns one credit
//   FIFO_READ_EN  out  one-hot read strobe to the granted FIFO (combinational)
//   ENABLE_CORE   out  core data valid, one cycle after the FIFO read
//   CH_SEL        out  channel tag for the current ENABLE_CORE
//   OUT_WRITE_EN  out  output FIFO write strobe (core result valid)
//   OUT_CH        out  channel tag accompanying OUT_WRITE_EN
//   CREDITS       out  free output FIFO slots
//   BUSY          out  not idle, or an item is still in flight
// ---------------------------------------------------------------------------
module get_rr_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int CORE_LATENCY = 3,
  parameter int OUT_DEPTH    = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic [NUM_CH-1:0] EMPTY,
  input  logic              OUT_READ,
  output logic [NUM_CH-1:0] FIFO_READ_EN,
  output logic              ENABLE_CORE,
  output logic [CH_W-1:0]   CH_SEL,
  output logic              OUT_WRITE_EN,
  output logic [CH_W-1:0]   OUT_CH,
  output logic [7:0]        CREDITS,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Last granted channel. It resets to NUM_CH-1 so that the first search
  // starts at channel 0.
  logic [CH_W-1:0] ptr;

  // Grant search results
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] grant_ch;
  logic            found;
  logic            issue;

  // Credit arithmetic uses one extra bit so that the clamp can see a result
  // of OUT_DEPTH+1.
  logic [8:0] credit_sum;

  // Valid/tag shift register that runs beside the core. Stage k holds the
  // item that entered the core k cycles ago. The last stage is the output.
  logic [CORE_LATENCY:1] vld_lat;
  logic [CH_W-1:0]       tag_lat [1:CORE_LATENCY];

  // True when an item will still be inside the pipeline after the next
  // edge. The final stage is left out: an item there leaves on the next
  // edge. This lets DRAIN reach IDLE on the same edge that retires the last
  // write.
  logic pending;

  // ---------------------------------------------------------------------
  // Round-robin grant: walk from ptr+1 with wrap-around. Take the first
  // channel whose FIFO is not empty.
  // ---------------------------------------------------------------------
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    cand     = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + CH_W'(1);
      if (!found && !EMPTY[cand]) begin
        found    = 1'b1;
        grant_ch = cand;
      end
    end
  end

  // ENABLE is checked directly. A drop in the RUN cycle then stops the
  // issue in that same cycle, before the state register catches up.
  assign issue = (state == RUN) && ENABLE && (CREDITS != 8'd0) && found;

  always_comb begin
    FIFO_READ_EN = '0;
    if (issue) begin
      FIFO_READ_EN[grant_ch] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Credits: an issue reserves a slot and an output pop frees one. If both
  // happen in the same cycle, they cancel. A pop at full credit is ignored
  // by the clamp.
  // ---------------------------------------------------------------------
  always_comb begin
    credit_sum = {1'b0, CREDITS} - {8'd0, issue} + {8'd0, OUT_READ};
    if (credit_sum > 9'(OUT_DEPTH)) begin
      credit_sum = 9'(OUT_DEPTH);
    end
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  always_comb begin
    pending = ENABLE_CORE;
    for (int k = 1; k < CORE_LATENCY; k++) begin
      pending = pending | vld_lat[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ENABLE) state_nxt = RUN;
      end
      RUN: begin
        if (!ENABLE) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ENABLE)        state_nxt = RUN;
        else if (!pending) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      ptr     <= CH_W'(NUM_CH - 1);
      CREDITS <= 8'(OUT_DEPTH);
    end else begin
      state   <= state_nxt;
      CREDITS <= credit_sum[7:0];
      if (issue) begin
        ptr <= grant_ch;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO read -> core enable (one-cycle FIFO read latency). CH_SEL keeps
  // the last tag between issues.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ENABLE_CORE <= 1'b0;
      CH_SEL      <= '0;
    end else begin
      ENABLE_CORE <= issue;
      if (issue) begin
        CH_SEL <= grant_ch;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Core latency tracking: ENABLE_CORE/CH_SEL shift through CORE_LATENCY
  // stages. The tags are also cleared on reset, so OUT_CH starts at zero.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_lat <= '0;
      for (int k = 1; k <= CORE_LATENCY; k++) begin
        tag_lat[k] <= '0;
      end
    end else begin
      vld_lat[1] <= ENABLE_CORE;
      tag_lat[1] <= CH_SEL;
      for (int k = 2; k <= CORE_LATENCY; k++) begin
        vld_lat[k] <= vld_lat[k-1];
        tag_lat[k] <= tag_lat[k-1];
      end
    end
  end

  assign OUT_WRITE_EN = vld_lat[CORE_LATENCY];
  assign OUT_CH       = tag_lat[CORE_LATENCY];

  assign BUSY = (state != IDLE) || ENABLE_CORE || (|vld_lat);

endmodule

// File: tb/tb_get_rr_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for get_rr_scheduler (NUM_CH=4, CORE_LATENCY=3,
// OUT_DEPTH=8). Inputs change on the falling edge. Outputs are sampled
// 1 time unit later, so combinational FIFO_READ_EN reflects the new inputs.
// Registered outputs reflect the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_get_rr_scheduler;

  localparam int NUM_CH       = 4;
  localparam int CH_W         = 2;
  localparam int CORE_LATENCY = 3;
  localparam int OUT_DEPTH    = 8;

  logic              CLK;
  logic              RESET_N;
  logic              ENABLE;
  logic [NUM_CH-1:0] EMPTY;
  logic              OUT_READ;
  logic [NUM_CH-1:0] FIFO_READ_EN;
  logic              ENABLE_CORE;
  logic [CH_W-1:0]   CH_SEL;
  logic              OUT_WRITE_EN;
  logic [CH_W-1:0]   OUT_CH;
  logic [7:0]        CREDITS;
  logic              BUSY;

  int checks = 0;
  int errors = 0;

  get_rr_scheduler #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .CORE_LATENCY(CORE_LATENCY),
    .OUT_DEPTH   (OUT_DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .EMPTY       (EMPTY),
    .OUT_READ    (OUT_READ),
    .FIFO_READ_EN(FIFO_READ_EN),
    .ENABLE_CORE (ENABLE_CORE),
    .CH_SEL      (CH_SEL),
    .OUT_WRITE_EN(OUT_WRITE_EN),
    .OUT_CH      (OUT_CH),
    .CREDITS     (CREDITS),
    .BUSY        (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then settle
  task automatic step(input logic en, input logic [3:0] emp, input logic rd);
    @(negedge CLK);
    ENABLE   = en;
    EMPTY    = emp;
    OUT_READ = rd;
    #1;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET_N  = 1'b0;
    ENABLE   = 1'b0;
    EMPTY    = 4'hF;
    OUT_READ = 1'b0;
    @(negedge CLK);
    RESET_N  = 1'b1;
  endtask

  initial begin
    RESET_N  = 1'b0;
    ENABLE   = 1'b0;
    EMPTY    = 4'hF;
    OUT_READ = 1'b0;
    #12;
    // Reset values
    chk("rst_rd",     32'(FIFO_READ_EN), 32'h0);
    chk("rst_ec",     32'(ENABLE_CORE),  32'h0);
    chk("rst_sel",    32'(CH_SEL),       32'h0);
    chk("rst_ow",     32'(OUT_WRITE_EN), 32'h0);
    chk("rst_och",    32'(OUT_CH),       32'h0);
    chk("rst_credit", 32'(CREDITS),      32'd8);
    chk("rst_busy",   32'(BUSY),         32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // All channels ready, output drained every cycle: rotation 0,1,2,3,0...
    step(1'b1, 4'b0000, 1'b1);
    chk("t1_idle_rd", 32'(FIFO_READ_EN), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'b0000, 1'b1);
      chk("t1_rd",     32'(FIFO_READ_EN), 32'(1 << ((i - 1) % 4)));
      chk("t1_ec",     32'(ENABLE_CORE),  32'(i >= 2));
      chk("t1_sel",    32'(CH_SEL),       (i >= 2) ? 32'((i - 2) % 4) : 32'h0);
      chk("t1_ow",     32'(OUT_WRITE_EN), 32'(i >= 5));
      chk("t1_och",    32'(OUT_CH),       (i >= 5) ? 32'((i - 5) % 4) : 32'h0);
      chk("t1_credit", 32'(CREDITS),      32'd8);
      chk("t1_busy",   32'(BUSY),         32'h1);
    end

    // Only ch0 and ch2 ready (last grant was ch3): 0001,0100,0001,...
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 4'b1010, 1'b1);
      chk("t2_rd", 32'(FIFO_READ_EN), (j % 2 == 0) ? 32'h1 : 32'h4);
    end

    // Credit exhaustion: no pops, exactly 8 issues
    do_reset();
    step(1'b1, 4'b0000, 1'b0);
    chk("t3_idle_credit", 32'(CREDITS), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      chk("t3_credit", 32'(CREDITS),      32'(9 - i));
      chk("t3_rd",     32'(FIFO_READ_EN), 32'(1 << ((i - 1) % 4)));
    end
    step(1'b1, 4'b0000, 1'b0);
    chk("t3_empty_rd",     32'(FIFO_READ_EN), 32'h0);
    chk("t3_empty_credit", 32'(CREDITS),      32'd0);
    step(1'b1, 4'b0000, 1'b0);
    chk("t3_hold_rd", 32'(FIFO_READ_EN), 32'h0);
    step(1'b1, 4'b0000, 1'b1);
    chk("t3_pop_rd",     32'(FIFO_READ_EN), 32'h0);
    chk("t3_pop_credit", 32'(CREDITS),      32'd0);
    step(1'b1, 4'b0000, 1'b0);
    chk("t3_one_credit", 32'(CREDITS),      32'd1);
    chk("t3_one_rd",     32'(FIFO_READ_EN), 32'h1);
    step(1'b1, 4'b0000, 1'b0);
    chk("t3_after_credit", 32'(CREDITS),      32'd0);
    chk("t3_after_rd",     32'(FIFO_READ_EN), 32'h0);

    // Simultaneous issue and pop at CREDITS=1
    step(1'b1, 4'b0000, 1'b1);
    chk("t6_pre_rd", 32'(FIFO_READ_EN), 32'h0);
    step(1'b1, 4'b0000, 1'b1);
    chk("t6_both_credit", 32'(CREDITS),      32'd1);
    chk("t6_both_rd",     32'(FIFO_READ_EN), 32'h2);
    step(1'b1, 4'b0000, 1'b0);
    chk("t6_next_credit", 32'(CREDITS),      32'd1);
    chk("t6_next_rd",     32'(FIFO_READ_EN), 32'h4);
    step(1'b1, 4'b0000, 1'b0);
    chk("t6_end_credit", 32'(CREDITS),      32'd0);
    chk("t6_end_rd",     32'(FIFO_READ_EN), 32'h0);

    // Pop at full credit is ignored
    do_reset();
    step(1'b0, 4'hF, 1'b1);
    chk("t6_full_a", 32'(CREDITS), 32'd8);
    step(1'b0, 4'hF, 1'b1);
    chk("t6_full_b", 32'(CREDITS), 32'd8);
    step(1'b0, 4'hF, 1'b0);
    chk("t6_full_c", 32'(CREDITS), 32'd8);

    // ENABLE drop after 5 issues: drain, then back to IDLE
    do_reset();
    step(1'b1, 4'b0000, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 4'b0000, 1'b1);
      chk("t4_rd", 32'(FIFO_READ_EN), 32'(1 << ((i - 1) % 4)));
    end
    for (int s = 6; s <= 12; s++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("t4_rd_off", 32'(FIFO_READ_EN), 32'h0);
      chk("t4_ow",     32'(OUT_WRITE_EN), 32'(s <= 9));
      chk("t4_busy",   32'(BUSY),         32'(s <= 9));
      if (s <= 9) begin
        chk("t4_och", 32'(OUT_CH), 32'((s - 5) % 4));
      end
    end
    step(1'b1, 4'b0000, 1'b1);
    chk("t4_idle_rd", 32'(FIFO_READ_EN), 32'h0);
    step(1'b1, 4'b0000, 1'b1);
    chk("t4_resume_rd", 32'(FIFO_READ_EN), 32'h2);

    // Asynchronous reset with 3 items in flight
    do_reset();
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 4'b0000, 1'b0);
    end
    @(negedge CLK);
    EMPTY = 4'hF;
    #1;
    chk("t5_pre_credit", 32'(CREDITS),     32'd5);
    chk("t5_pre_busy",   32'(BUSY),        32'h1);
    chk("t5_pre_ec",     32'(ENABLE_CORE), 32'h1);
    chk("t5_pre_sel",    32'(CH_SEL),      32'h2);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("t5_rst_ec",     32'(ENABLE_CORE),  32'h0);
    chk("t5_rst_ow",     32'(OUT_WRITE_EN), 32'h0);
    chk("t5_rst_credit", 32'(CREDITS),      32'd8);
    chk("t5_rst_busy",   32'(BUSY),         32'h0);
    chk("t5_rst_sel",    32'(CH_SEL),       32'h0);
    chk("t5_rst_rd",     32'(FIFO_READ_EN), 32'h0);
    @(negedge CLK);
    ENABLE  = 1'b0;
    RESET_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'hF, 1'b0);
      chk("t5_no_ow", 32'(OUT_WRITE_EN), 32'h0);
    end
    step(1'b1, 4'b0000, 1'b0);
    chk("t5_idle_rd", 32'(FIFO_READ_EN), 32'h0);
    step(1'b1, 4'b0000, 1'b0);
    chk("t5_first_rd", 32'(FIFO_READ_EN), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
